// File: rtl/la_iotxdiff_pkg.sv
// Shared definitions for the differential serializing tx pad block:
// FSM state encoding, cfg bit positions and the per-lane control bundle.
package la_iotxdiff_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_OFF   = 2'd0;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd1;
    localparam logic [STATE_W-1:0] ST_SHIFT = 2'd2;
    localparam logic [STATE_W-1:0] ST_TRAIN = 2'd3;

    localparam int unsigned CFG_TRAIN  = 0;
    localparam int unsigned CFG_INVERT = 1;
    localparam int unsigned CFG_MSB    = 2;

    // What every lane does on the coming edge; decoded once from the shared FSM.
    typedef struct packed {
        logic drive;
        logic load;
        logic shift;
        logic train;
    } lane_ctrl_t;

endpackage

// File: rtl/la_iotxdiff_lane.sv
// One differential lane: shift register plus registered pad data/enable.
// Pads only ever see flop outputs.
module la_iotxdiff_lane
    import la_iotxdiff_pkg::*;
#(
    parameter int unsigned W = 8
)
(
    input  logic         clk,
    input  logic         nreset,
    input  lane_ctrl_t   ctrl,
    input  logic         msb_load,
    input  logic         msb_q,
    input  logic         invert,
    input  logic         train_bit,
    input  logic [W-1:0] data,
    output logic         pad_p,
    output logic         pad_n,
    output logic         pad_oe
);

    logic [W-1:0] sr;
    logic         bit_c;

    // Bit to present next: first bit straight from the word on load, then from sr.
    always_comb begin
        bit_c = 1'b0;
        if (ctrl.load) begin
            bit_c = msb_load ? data[W-1] : data[0];
        end else if (ctrl.shift) begin
            bit_c = msb_q ? sr[W-1] : sr[0];
        end else if (ctrl.train) begin
            bit_c = train_bit;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sr     <= '0;
            pad_p  <= 1'b0;
            pad_n  <= 1'b0;
            pad_oe <= 1'b0;
        end else begin
            if (!ctrl.drive) begin
                sr <= '0;
            end else if (ctrl.load) begin
                sr <= msb_load ? (data << 1) : (data >> 1);
            end else if (ctrl.shift) begin
                sr <= msb_q ? (sr << 1) : (sr >> 1);
            end
            pad_oe <= ctrl.drive;
            pad_p  <= ctrl.drive & (bit_c ^ invert);
            pad_n  <= ctrl.drive & ~(bit_c ^ invert);
        end
    end

endmodule

// File: rtl/la_iotxdiffser.sv
// Differential tx serializer: N lanes of W:1 serialization with idle,
// training pattern, polarity swap and output-enable control.
module la_iotxdiffser
    import la_iotxdiff_pkg::*;
#(
    parameter              PROP  = "DEFAULT",
    parameter              SIDE  = "NO",
    parameter int unsigned CFGW  = 16,
    parameter int unsigned RINGW = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 8
)
(
    input  logic             clk,
    input  logic             nreset,
    inout  wire  [N-1:0]     padp,
    inout  wire  [N-1:0]     padn,
    inout  wire              vdd,
    inout  wire              vss,
    inout  wire              vddio,
    inout  wire              vssio,
    input  logic [N*W-1:0]   data,
    input  logic             valid,
    output logic             ready,
    input  logic             oe,
    inout  wire  [RINGW-1:0] ioring,
    input  logic [CFGW-1:0]  cfg
);

    localparam int unsigned CNTW = $clog2(W);
    localparam logic [CNTW-1:0] LAST = CNTW'(W - 1);

    // Technology hooks and supplies have no behavioural role here.
    localparam int unsigned unused_params = $bits(PROP) + ((SIDE == "NO") ? 0 : 1);
    logic unused_ok;
    assign unused_ok = &{1'b0, cfg, vdd, vss, vddio, vssio, ioring};

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               ready_q;
    logic               tog_q;
    logic               msb_q;
    logic               xfer_c;
    logic               last_c;
    logic               tbit_c;
    lane_ctrl_t         ctrl_c;
    logic [N-1:0]       pad_p, pad_n, pad_oe;

    // ready is held in a flop; oe gates it so a dropped oe blocks transfers at once.
    assign ready = oe & ready_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ctrl_c  = '0;
        xfer_c  = valid & ready;
        last_c  = (cnt_q == LAST);
        tbit_c  = (state_q == ST_TRAIN) ? ~tog_q : 1'b1;

        if (!oe) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:   state_d = ST_IDLE;
                ST_IDLE: begin
                    // A pending word beats a training request.
                    if (xfer_c) begin
                        state_d = ST_SHIFT;
                    end else if (cfg[CFG_TRAIN]) begin
                        state_d = ST_TRAIN;
                    end
                end
                ST_SHIFT: begin
                    if (!last_c) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end else if (!xfer_c) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TRAIN: begin
                    if (!cfg[CFG_TRAIN]) begin
                        state_d = ST_IDLE;
                    end
                end
                default:  state_d = ST_OFF;
            endcase
        end

        ctrl_c.drive = (state_d != ST_OFF);
        ctrl_c.load  = xfer_c;
        ctrl_c.shift = (state_d == ST_SHIFT) & ~xfer_c;
        ctrl_c.train = (state_d == ST_TRAIN);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            tog_q   <= 1'b0;
            msb_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_IDLE) | ((state_d == ST_SHIFT) & (cnt_d == LAST));
            tog_q   <= ctrl_c.train & tbit_c;
            if (xfer_c) begin
                msb_q <= cfg[CFG_MSB];
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        la_iotxdiff_lane #(.W(W)) u_lane (
            .clk       (clk),
            .nreset    (nreset),
            .ctrl      (ctrl_c),
            .msb_load  (cfg[CFG_MSB]),
            .msb_q     (msb_q),
            .invert    (cfg[CFG_INVERT]),
            .train_bit (tbit_c),
            .data      (data[k*W +: W]),
            .pad_p     (pad_p[k]),
            .pad_n     (pad_n[k]),
            .pad_oe    (pad_oe[k])
        );
        assign padp[k] = pad_oe[k] ? pad_p[k] : 1'bz;
        assign padn[k] = pad_oe[k] ? pad_n[k] : 1'bz;
    end

endmodule

// File: tb/tb_la_iotxdiffser.sv
// Bench for la_iotxdiffser (N=2, W=4): directed scenarios plus random traffic
// against a queue-based reference model. Pads are pulled up so high-Z reads as all ones.
module tb_la_iotxdiffser;

    localparam int unsigned N     = 2;
    localparam int unsigned W     = 4;
    localparam int unsigned DW    = N * W;
    localparam int unsigned CFGW  = 16;
    localparam int unsigned RINGW = 8;

    logic            clk = 1'b0;
    logic            nreset;
    logic [DW-1:0]   data;
    logic            valid;
    logic            oe;
    logic [CFGW-1:0] cfg;
    logic            ready;
    tri1  [N-1:0]    padp;
    tri1  [N-1:0]    padn;
    wire             vdd, vss, vddio, vssio;
    wire [RINGW-1:0] ioring;

    assign vdd    = 1'b1;
    assign vss    = 1'b0;
    assign vddio  = 1'b1;
    assign vssio  = 1'b0;
    assign ioring = 8'h3C;

    la_iotxdiffser #(.PROP("DEFAULT"), .SIDE("NO"), .CFGW(CFGW), .RINGW(RINGW), .N(N), .W(W)) dut (
        .clk(clk), .nreset(nreset), .padp(padp), .padn(padn),
        .vdd(vdd), .vss(vss), .vddio(vddio), .vssio(vssio),
        .data(data), .valid(valid), .ready(ready), .oe(oe),
        .ioring(ioring), .cfg(cfg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the pads show this cycle, plus bits still owed.
    bit           m_drv, m_data, m_train, m_inv;
    logic [N-1:0] m_cur;
    logic [N-1:0] m_q[$];

    function automatic logic [2*N-1:0] exp_pads();
        logic [N-1:0] p;
        if (!m_drv) return {(2*N){1'b1}};
        p = m_cur ^ {N{m_inv}};
        return {p, ~p};
    endfunction

    function automatic bit exp_ready();
        return oe && m_drv && !m_train && (!m_data || m_q.size() == 0);
    endfunction

    task automatic model_clear();
        m_drv = 0; m_data = 0; m_train = 0; m_cur = '0; m_q.delete();
    endtask

    task automatic model_edge();
        bit rdy;
        rdy = exp_ready();
        if (!nreset || !oe) begin
            model_clear();
            return;
        end
        m_inv = cfg[1];
        if (!m_drv) begin
            m_drv = 1; m_cur = '0;
        end else if (valid && rdy) begin
            m_q.delete();
            for (int i = 0; i < W; i++) begin
                logic [N-1:0] v;
                for (int k = 0; k < N; k++)
                    v[k] = cfg[2] ? data[k*W + W - 1 - i] : data[k*W + i];
                m_q.push_back(v);
            end
            m_cur = m_q.pop_front(); m_data = 1; m_train = 0;
        end else if (m_data && m_q.size() != 0) begin
            m_cur = m_q.pop_front();
        end else if (m_train && cfg[0]) begin
            m_cur = ~m_cur;
        end else if (!m_data && !m_train && cfg[0]) begin
            m_train = 1; m_cur = '1;
        end else begin
            m_data = 0; m_train = 0; m_cur = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        nreset = 1'b0; oe = 1'b1; valid = 1'b0; data = '0; cfg = '0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({padp, padn} !== 4'b1111 || ready !== 1'b0) begin
                n_bad++; $display("FAIL reset_hold: pads=%b ready=%b want pads=1111 ready=0", {padp, padn}, ready);
            end
        end
        nreset = 1'b1; oe = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step(); #1;
            n_cmp++;
            if ({padp, padn} !== 4'b1111 || ready !== 1'b0) begin
                n_bad++; $display("FAIL reset_needs_oe: pads=%b ready=%b want 1111/0", {padp, padn}, ready);
            end
        end
        oe = 1'b1; #1;
        n_cmp++;
        if ({padp, padn} !== 4'b1111 || ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_off_oe: pads=%b ready=%b want 1111/0", {padp, padn}, ready);
        end
        step(); #1;
        n_cmp++;
        if ({padp, padn} !== 4'b0011 || ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_to_idle: pads=%b ready=%b want 0011/1", {padp, padn}, ready);
        end
    endtask

    task automatic test_single_word();
        logic [N-1:0] want [W] = '{2'b01, 2'b10, 2'b01, 2'b10};
        data = 8'hA5; valid = 1'b1; #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++; $display("FAIL single_accept: ready=%b want 1", ready);
        end
        step(); valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            #1;
            n_cmp++;
            if (padp !== want[i] || padn !== ~want[i]) begin
                n_bad++; $display("FAIL single_bit%0d: padp=%b padn=%b want padp=%b", i, padp, padn, want[i]);
            end
            step();
        end
        #1;
        n_cmp++;
        if ({padp, padn} !== 4'b0011 || ready !== 1'b1) begin
            n_bad++; $display("FAIL single_idle: pads=%b ready=%b want 0011/1", {padp, padn}, ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j <= 2*W; j++) begin
            valid = (j <= W);
            data  = (j == 0) ? 8'h0F : 8'hF0;
            #1;
            n_cmp++;
            if (ready !== (j == 0 || j == W || j == 2*W)) begin
                n_bad++; $display("FAIL b2b_ready c%0d: ready=%b want %b", j, ready, (j == 0 || j == W || j == 2*W));
            end
            if (j >= 1) begin
                n_cmp++;
                if (padp !== ((j <= W) ? 2'b01 : 2'b10) || padn !== ~padp) begin
                    n_bad++; $display("FAIL b2b_pads c%0d: padp=%b padn=%b want padp=%b", j, padp, padn, (j <= W) ? 2'b01 : 2'b10);
                end
            end
            if (j == 2*W) valid = 1'b0;
            step();
        end
        #1;
        n_cmp++;
        if ({padp, padn} !== 4'b0011) begin
            n_bad++; $display("FAIL b2b_idle: pads=%b want 0011", {padp, padn});
        end
    endtask

    task automatic test_oe_abort();
        data = 8'hA5; valid = 1'b1;
        step(); valid = 1'b0;
        step(); step();
        #1;
        n_cmp++;
        if (padp !== 2'b01) begin
            n_bad++; $display("FAIL abort_bit2: padp=%b want 01", padp);
        end
        oe = 1'b0; #1;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++; $display("FAIL abort_ready_comb: ready=%b want 0", ready);
        end
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            n_cmp++;
            if ({padp, padn} !== 4'b1111 || ready !== 1'b0) begin
                n_bad++; $display("FAIL abort_off c%0d: pads=%b ready=%b want 1111/0", c, {padp, padn}, ready);
            end
        end
        oe = 1'b1;
        step(); #1;
        n_cmp++;
        if ({padp, padn} !== 4'b0011 || ready !== 1'b1) begin
            n_bad++; $display("FAIL abort_reenable: pads=%b ready=%b want 0011/1", {padp, padn}, ready);
        end
    endtask

    task automatic test_train();
        cfg = 16'h0001; #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++; $display("FAIL train_idle_ready: ready=%b want 1", ready);
        end
        step();
        for (int j = 1; j <= 5; j++) begin
            #1;
            n_cmp++;
            if (padp !== ((j % 2) ? 2'b11 : 2'b00) || padn !== ~padp || ready !== 1'b0) begin
                n_bad++; $display("FAIL train_pattern c%0d: padp=%b padn=%b ready=%b want padp=%b ready=0", j, padp, padn, ready, (j % 2) ? 2'b11 : 2'b00);
            end
            if (j == 5) cfg = '0;
            step();
        end
        #1;
        n_cmp++;
        if ({padp, padn} !== 4'b0011 || ready !== 1'b1) begin
            n_bad++; $display("FAIL train_exit: pads=%b ready=%b want 0011/1", {padp, padn}, ready);
        end
        // Training request together with a word: the word goes first.
        cfg = 16'h0001; data = 8'h0F; valid = 1'b1;
        step(); valid = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            #1;
            n_cmp++;
            if (padp !== ((j <= W) ? 2'b01 : (j == 6) ? 2'b11 : 2'b00) || padn !== ~padp) begin
                n_bad++; $display("FAIL train_vs_word c%0d: padp=%b padn=%b", j, padp, padn);
            end
            step();
        end
        cfg = '0;
        step(); #1;
        n_cmp++;
        if ({padp, padn} !== 4'b0011) begin
            n_bad++; $display("FAIL train_vs_word_exit: pads=%b want 0011", {padp, padn});
        end
    endtask

    task automatic test_invert_msb();
        logic [N-1:0] want_p [W] = '{2'b11, 2'b11, 2'b11, 2'b10};
        cfg = 16'h0006;
        step(); #1;
        n_cmp++;
        if ({padp, padn} !== 4'b1100) begin
            n_bad++; $display("FAIL inv_idle: pads=%b want 1100", {padp, padn});
        end
        data = 8'h01; valid = 1'b1;
        step(); valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            #1;
            n_cmp++;
            if (padp !== want_p[i] || padn !== ~want_p[i]) begin
                n_bad++; $display("FAIL inv_msb_bit%0d: padp=%b padn=%b want padp=%b", i, padp, padn, want_p[i]);
            end
            step();
        end
        cfg = '0;
        step(); #1;
        n_cmp++;
        if ({padp, padn} !== 4'b0011) begin
            n_bad++; $display("FAIL inv_clear: pads=%b want 0011", {padp, padn});
        end
    endtask

    task automatic test_reset_midword();
        data = 8'hFF; valid = 1'b1;
        step(); valid = 1'b0;
        step();
        nreset = 1'b0; model_clear(); #1;
        n_cmp++;
        if ({padp, padn} !== 4'b1111 || ready !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_async: pads=%b ready=%b want 1111/0", {padp, padn}, ready);
        end
        step(); step();
        nreset = 1'b1; #1;
        n_cmp++;
        if ({padp, padn} !== 4'b1111) begin
            n_bad++; $display("FAIL rstmid_release: pads=%b want 1111", {padp, padn});
        end
        for (int c = 0; c < W + 1; c++) begin
            step(); #1;
            n_cmp++;
            if ({padp, padn} !== 4'b0011 || ready !== 1'b1) begin
                n_bad++; $display("FAIL rstmid_no_stale c%0d: pads=%b ready=%b want 0011/1", c, {padp, padn}, ready);
            end
        end
    endtask

    task automatic test_random();
        bit train_s = 0;
        bit inv_s   = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) train_s = ~train_s;
            if ($urandom_range(0, 29) == 0) inv_s = ~inv_s;
            oe    = ($urandom_range(0, 24) != 0);
            valid = ($urandom_range(0, 2) != 0);
            data  = DW'($urandom);
            cfg   = CFGW'($urandom);
            cfg[0] = train_s;
            cfg[1] = inv_s;
            #1;
            n_cmp++;
            if ({padp, padn} !== exp_pads()) begin
                n_bad++; $display("FAIL rand_pads c%0d: pads=%b want %b", c, {padp, padn}, exp_pads());
            end
            n_cmp++;
            if (ready !== exp_ready()) begin
                n_bad++; $display("FAIL rand_ready c%0d: ready=%b want %b", c, ready, exp_ready());
            end
            step();
        end
        oe = 1'b1; valid = 1'b0; cfg = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_oe_abort();
        test_train();
        test_invert_msb();
        test_reset_midword();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/la_iotxdiffser.md
LA_IOTXDIFFSER -- requirements
Module: la_iotxdiffser

Interface
REQ-001 Parameter PROP, "DEFAULT", cell property passed to the technology implementation.
REQ-002 Parameter SIDE, "NO", placement side, one of "NO", "SO", "EA", "WE".
REQ-003 Parameter CFGW, 16, width of the core config bus (minimum 3).
REQ-004 Parameter RINGW, 8, width of the io ring bus.
REQ-005 Parameter N, 4, number of differential lanes (minimum 1).
REQ-006 Parameter W, 8, serialization ratio in bits per lane per word (minimum 2).
REQ-007 The clock shall be `clk`, input, 1 bit, the bit clock; all state shall update on its rising edge.
REQ-008 The reset shall be `nreset`, input, 1 bit, asynchronous and active-low.
REQ-009 `padp`, inout, N bits: positive pad per lane.
REQ-010 `padn`, inout, N bits: negative pad per lane.
REQ-011 `vdd`, `vss`, `vddio` and `vssio` shall each be inout, 1 bit: core supply, core ground, io supply and io ground.
REQ-012 `data`, input, N*W bits: parallel word; lane k uses bits [k*W+W-1 : k*W].
REQ-013 `valid`, input, 1 bit: `data` is valid.
REQ-014 `ready`, output, 1 bit: the block accepts `data` this cycle.
REQ-015 `oe`, input, 1 bit: output enable, 1 = active.
REQ-016 `ioring`, inout, RINGW bits: generic io ring interface, passed through untouched.
REQ-017 `cfg`, input, CFGW bits: bit 0 is train, bit 1 is invert, bit 2 is MSB-first; the remaining bits are reserved.

Function
REQ-018 The FSM shall have the states OFF, IDLE, SHIFT and TRAIN.
REQ-019 In OFF, the block shall drive padp and padn to high-Z and hold ready at 0.
REQ-020 OFF shall go to IDLE on the cycle after oe is sampled at 1.
REQ-021 In IDLE, each lane shall drive padp=0 and padn=1 (before invert), with ready=1.
REQ-022 A transfer shall occur when valid and ready are both 1; the word is loaded into the shift register, the bit counter is cleared and the next state is SHIFT.
REQ-023 Latency: for a word accepted at cycle t, bit i shall appear on the pads at cycle t+1+i, for i = 0..W-1.
REQ-024 Bit order shall be LSB-first when cfg[2]=0 and MSB-first when cfg[2]=1; cfg[2] shall be sampled only at acceptance.
REQ-025 In SHIFT, ready shall be 1 only when the bit counter equals W-1, which allows back-to-back words with no idle bit.
REQ-026 On the last bit, SHIFT shall reload and stay in SHIFT if a transfer occurs, otherwise go to IDLE.
REQ-027 The bit counter shall be $clog2(W) bits wide and wrap from W-1 to 0.
REQ-028 When IDLE samples cfg[0]=1, the block shall enter TRAIN, with ready=0.
REQ-029 In TRAIN, all lanes shall drive padp = 1,0,1,0,... starting with 1.
REQ-030 TRAIN shall exit to IDLE on the cycle after cfg[0]=0 is sampled.
REQ-031 In IDLE, cfg[0]=1 and valid=1 in the same cycle shall resolve as: the transfer wins, and TRAIN is entered only after the word completes.
REQ-032 When cfg[1]=1, padp and padn shall be swapped on every lane in all driven states.
REQ-033 padn shall always equal ~padp when the pads are driven.
REQ-034 oe=0 sampled in any state shall force OFF on the next cycle, abort any word in flight, discard it and drive ready=0.
REQ-035 While oe=0, ready shall be combinationally 0.
REQ-036 Pad data and pad enable shall come directly from flops, with no combinational path from any input to the pads.

Reset
REQ-037 While nreset=0, the state shall be OFF, the shift register 0, the bit counter 0, the train toggle 0, the pad enable 0 (pads high-Z) and ready 0.
REQ-038 Reset asserted mid-word shall drop the word, and no bit of it shall appear after nreset rises.
REQ-039 After nreset rises, the block shall need an oe=1 sample before it leaves OFF.

Structure
REQ-040 The FSM state encoding and the cfg bit indices shall live in the shared package la_iotxdiff_pkg.
REQ-041 The per-lane shift register and pad driver shall be one sub-module, la_iotxdiff_lane, instantiated N times; the FSM and bit counter shall be shared.

Verification
REQ-042 Reset: nreset=0 with oe=1 -> pads high-Z and ready=0; after release -> IDLE one cycle later with lanes padp=0 and padn=1.
REQ-043 Single word (N=2, W=4), data=8'hA5, cfg=0: lane0 padp=1,0,1,0 and lane1 padp=0,1,0,1 at cycles t+1..t+4, with padn the complement, then IDLE.
REQ-044 Back-to-back 8'h0F then 8'hF0 with valid held high: lane0 padp=1,1,1,1,0,0,0,0 with no gap, and ready=1 exactly on cycles t and t+4.
REQ-045 oe drops while bit 2 is on the pads: pads high-Z on the next cycle, ready=0, and no further bits; re-enabling returns to IDLE.
REQ-046 cfg[0]=1 in IDLE -> both lanes padp=1,0,1,0 with ready=0; cfg[0]=0 -> IDLE next cycle and ready=1.
REQ-047 cfg[1]=1 and cfg[2]=1 with data=8'h01 -> lane0 padn=0,0,0,1 and padp=1,1,1,0.
